// File: rtl/bcd_sevenseg_mux.sv
// Three-digit multiplexed BCD to seven-segment driver with blanking gaps between digits.
// Optional leading-zero blanking is enabled by defining BCDMUX_LEADING_ZERO_BLANK_EN.
module bcd_sevenseg_mux #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int GAP_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd,
    input  logic        load,
    output logic [2:0]  an_n,
    output logic [6:0]  seg_n
);

    localparam int              CW       = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0]   GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]   ON_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [2:0]      AN_OFF   = 3'b111;
    localparam logic [6:0]      SEG_OFF  = 7'h7F;

    typedef enum logic {
        ST_GAP = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    state_t         r_state;
    logic [1:0]     r_idx;
    logic [CW-1:0]  r_cnt;
    logic [11:0]    r_shadow;
    logic [3:0]     r_disp;
    logic           r_blank;
    logic [2:0]     r_an_n;
    logic [6:0]     r_seg_n;

    logic [3:0]     w_nib;
    logic           w_blank;
    logic [1:0]     w_idx_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            default: seg = 7'h3F;
        endcase
        return seg;
    endfunction

    function automatic logic [2:0] an_decode(input logic [1:0] idx);
        logic [2:0] an;
        case (idx)
            2'd0:    an = 3'b110;
            2'd1:    an = 3'b101;
            2'd2:    an = 3'b011;
            default: an = 3'b111;
        endcase
        return an;
    endfunction

    function automatic logic [3:0] nibble_sel(input logic [11:0] sh, input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = sh[3:0];
            2'd1:    nib = sh[7:4];
            2'd2:    nib = sh[11:8];
            default: nib = sh[3:0];
        endcase
        return nib;
    endfunction

    assign w_nib      = nibble_sel(r_shadow, r_idx);
    assign w_idx_next = (r_idx == 2'd2) ? 2'd0 : (r_idx + 2'd1);

    // Leading-zero decision for the digit about to be lit, taken from the shadow at ON entry.
    always_comb begin
        w_blank = 1'b0;
`ifdef BCDMUX_LEADING_ZERO_BLANK_EN
        case (r_idx)
            2'd2:    w_blank = (r_shadow[11:8] == 4'h0);
            2'd1:    w_blank = (r_shadow[11:4] == 8'h00);
            default: w_blank = 1'b0;
        endcase
`else
        w_blank = 1'b0;
`endif
    end

    // Shadow register: captures the BCD word whenever load is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= 12'h000;
        end else if (load) begin
            r_shadow <= bcd;
        end else begin
            r_shadow <= r_shadow;
        end
    end

    // Scan FSM; outputs are registered from the state held before each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_GAP;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_disp  <= 4'h0;
            r_blank <= 1'b0;
            r_an_n  <= AN_OFF;
            r_seg_n <= SEG_OFF;
        end else begin
            case (r_state)
                ST_GAP: begin
                    r_an_n  <= AN_OFF;
                    r_seg_n <= SEG_OFF;
                    if (r_cnt == GAP_LAST) begin
                        // Nibble is frozen here so shadow updates mid-ON stay invisible.
                        r_state <= ST_ON;
                        r_cnt   <= '0;
                        r_disp  <= w_nib;
                        r_blank <= w_blank;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                ST_ON: begin
                    if (r_blank) begin
                        r_an_n  <= AN_OFF;
                        r_seg_n <= SEG_OFF;
                    end else begin
                        r_an_n  <= an_decode(r_idx);
                        r_seg_n <= seg_decode(r_disp);
                    end
                    if (r_cnt == ON_LAST) begin
                        r_state <= ST_GAP;
                        r_cnt   <= '0;
                        r_idx   <= w_idx_next;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_GAP;
                    r_idx   <= 2'd0;
                    r_cnt   <= '0;
                    r_an_n  <= AN_OFF;
                    r_seg_n <= SEG_OFF;
                end
            endcase
        end
    end

    assign an_n  = r_an_n;
    assign seg_n = r_seg_n;

endmodule
